// File: rtl/oam_dma_if.sv
// CPU-side bus bundle for the OAM DMA engine: snooped CPU cycle in, decoder-facing bus cycle out.
// The master drives the CPU-side inputs; the engine is the slave.
interface oam_dma_if;
  logic [15:0] address_in;
  logic        rw_in;
  logic [7:0]  data_in;
  logic [15:0] address_out;
  logic        rw_out;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        cpu_stall;
  logic        cpu_ram_read;
  logic        ppu_oam_write;
  logic        busy;
  logic        done;

  modport master (
    output address_in, rw_in, data_in,
    input  address_out, rw_out, data_out, data_oe, cpu_stall,
           cpu_ram_read, ppu_oam_write, busy, done
  );

  modport slave (
    input  address_in, rw_in, data_in,
    output address_out, rw_out, data_out, data_oe, cpu_stall,
           cpu_ram_read, ppu_oam_write, busy, done
  );
endinterface

// File: rtl/oam_dma_engine.sv
// Sprite DMA engine: snoops a trigger write, stalls the CPU and copies XFER_LEN bytes
// from page base to DEST_ADDR with alternating read/write cycles.
//
// state | meaning
// IDLE  | pass-through, watching for a CPU write to TRIG_ADDR
// HALT  | CPU stalled, its in-flight cycle still passes through
// ALIGN | one idle bus cycle so the first read lands on an even cycle
// READ  | read byte from base + idx into buffer
// WRITE | write buffer to DEST_ADDR, advance idx
// FIN   | stall released, done pulse, idx cleared
module oam_dma_engine #(
  parameter logic [15:0] TRIG_ADDR   = 16'h4014,
  parameter logic [15:0] DEST_ADDR   = 16'h2004,
  parameter int          XFER_LEN    = 256,
  parameter int          LEN_W       = 17,
  parameter int          ALIGN_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  oam_dma_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE,
    S_FIN
  } state_t;

  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(XFER_LEN - 1);

  state_t           state_q;
  state_t           state_d;
  logic [LEN_W-1:0] idx_q;
  logic             parity_q;
  logic [7:0]       page_q;
  logic [7:0]       buffer_q;
  logic [15:0]      base;
  logic [15:0]      idx16;
  logic             trig;
  logic             last;

  assign base  = {page_q, 8'h00};
  // Address arithmetic is 16-bit so long transfers wrap FFFF -> 0000.
  assign idx16 = 16'(idx_q);
  assign trig  = (state_q == S_IDLE) && !bus.rw_in && (bus.address_in == TRIG_ADDR);
  assign last  = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      buffer_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      if (trig) page_q <= bus.data_in;
      if (state_q == S_READ) buffer_q <= bus.data_in;
      if (state_q == S_WRITE && !last) idx_q <= idx_q + LEN_W'(1);
      if (state_q == S_FIN) idx_q <= '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trig) state_d = S_HALT;
      S_HALT:  state_d = ((ALIGN_CYCLE == 1) && parity_q) ? S_ALIGN : S_READ;
      S_ALIGN: state_d = S_READ;
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = last ? S_FIN : S_READ;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.address_out   = bus.address_in;
    bus.rw_out        = bus.rw_in;
    bus.data_out      = 8'h00;
    bus.data_oe       = 1'b0;
    bus.cpu_stall     = 1'b0;
    bus.cpu_ram_read  = 1'b0;
    bus.ppu_oam_write = 1'b0;
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    case (state_q)
      S_HALT: begin
        bus.cpu_stall = 1'b1;
        bus.busy      = 1'b1;
      end
      S_ALIGN: begin
        bus.rw_out    = 1'b1;
        bus.cpu_stall = 1'b1;
        bus.busy      = 1'b1;
      end
      S_READ: begin
        bus.address_out  = base + idx16;
        bus.rw_out       = 1'b1;
        bus.cpu_ram_read = 1'b1;
        bus.cpu_stall    = 1'b1;
        bus.busy         = 1'b1;
      end
      S_WRITE: begin
        bus.address_out   = DEST_ADDR;
        bus.rw_out        = 1'b0;
        bus.data_out      = buffer_q;
        bus.data_oe       = 1'b1;
        bus.ppu_oam_write = 1'b1;
        bus.cpu_stall     = 1'b1;
        bus.busy          = 1'b1;
      end
      S_FIN:   bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/oam_dma_engine.md
Name: oam_dma_engine

Overview:
- Parametrised successor to the sprite-DMA block that sits between the 6502 core and the address decoder.
- Snoops CPU writes to a trigger register.
- On a trigger, it stalls the CPU and copies a configurable-length block from CPU address space to a fixed destination register (PPU OAMDATA by default), alternating read and write bus cycles.
- Adds over the fixed-function version: configurable trigger and destination addresses, configurable length (beyond 256 bytes, with 16-bit wrap), an optional odd-cycle alignment slot, and a completion pulse.

Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts a transfer.
- DEST_ADDR, 16'h2004, address driven on every DMA write cycle.
- XFER_LEN, 256, bytes per transfer; legal range 1..65536.
- LEN_W, 17, counter width; must satisfy 2^LEN_W > XFER_LEN.
- ALIGN_CYCLE, 1, when 1, inserts one extra idle cycle if the transfer would start on an odd cycle.

Ports:
- clk  in  1  CPU-rate clock
- rst_n  in  1  asynchronous active-low reset
- address_in  in  16  CPU address
- rw_in  in  1  CPU read/write (1 = read, 0 = write)
- data_in  in  8  shared data bus value
- address_out  out  16  address to decoder
- rw_out  out  1  bus direction to decoder and memory
- data_out  out  8  byte driven during DMA write cycles
- data_oe  out  1  data_out is valid and must be placed on the bus
- cpu_stall  out  1  deasserts the CPU RDY input
- cpu_ram_read  out  1  high during DMA read cycles
- ppu_oam_write  out  1  high during DMA write cycles
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; idx = 0; parity = 0; page = 0; buffer = 0.
  - Outputs cpu_stall, cpu_ram_read, ppu_oam_write, data_oe, busy and done are all 0; data_out = 0.
  - address_out = address_in and rw_out = rw_in (combinational pass-through).
  - Reset mid-transfer aborts immediately with no further bus cycles.
- parity toggles every clk from reset; it is used only for alignment.
- IDLE:
  - Pass-through of address and rw.
  - If rw_in = 0 and address_in = TRIG_ADDR: register page <= data_in and base <= {data_in, 8'h00}, then go to HALT.
  - The trigger write itself completes normally through the pass-through.
- HALT (1 cycle):
  - cpu_stall = 1, busy = 1; pass-through continues so the CPU finishes its current cycle.
  - Next state is ALIGN if ALIGN_CYCLE = 1 and parity = 1; otherwise READ.
- ALIGN (1 cycle): cpu_stall = 1; bus idle (address_out = address_in, rw_out = 1).
- READ:
  - address_out = base + idx, computed modulo 2^16 (wraps FFFF -> 0000); rw_out = 1; cpu_ram_read = 1.
  - buffer <= data_in at the clock edge; next state WRITE.
- WRITE:
  - address_out = DEST_ADDR; rw_out = 0; data_out = buffer; data_oe = 1; ppu_oam_write = 1.
  - If idx = XFER_LEN-1, go to FIN; otherwise idx <= idx+1 and go to READ.
- FIN (1 cycle): done = 1, cpu_stall = 0, busy = 0, idx <= 0; next state IDLE.
- Timing: total stall cycles = 1 + align + 2*XFER_LEN. busy is high from HALT through the final WRITE inclusive.
- Trigger writes seen while not in IDLE are ignored (address_in is don't-care while stalled).
- A trigger in the FIN cycle is accepted on the next IDLE cycle only if the CPU is still presenting it.
- All state-machine outputs are registered-state decodes. Only the address/rw pass-through is combinational.
- No X on any output after reset release.

Test Plan:
- Basic transfer: XFER_LEN = 256, write 8'h02 to 16'h4014 on an even cycle, memory at 16'h0200+i holds i ^ 8'h5A.
  - Exactly 256 DMA writes to 16'h2004 carrying values 5A, 5B, ... in order.
  - cpu_stall high for 513 cycles; done pulses once.
- Alignment: same trigger but HALT lands on an odd parity cycle -> first READ is delayed by 1 cycle; stall lasts 514 cycles. With ALIGN_CYCLE = 0 -> stall lasts 513 cycles regardless of parity.
- Wrap: XFER_LEN = 512, trigger page 8'hFF.
  - Reads at FF00..FFFF, then 0000..00FF.
  - 512 writes; idx never exceeds 511.
- Retrigger: a second write to TRIG_ADDR during READ/WRITE cycles -> ignored; a single transfer of XFER_LEN bytes; page unchanged.
- Reset abort: rst_n pulsed low at the 100th WRITE.
  - All outputs go to reset values asynchronously; cpu_stall = 0.
  - After release, address_out tracks address_in; no further DMA cycles occur.
- Non-trigger traffic: CPU reads 16'h4014 and writes 16'h4015 -> no state change; busy = 0; pass-through exact.
